// File: rtl/multdiv_unit.sv
// Multicycle signed 32-bit multiply/divide unit: one shift-add or restoring-divide
// step per clock, with a pipeline stall while an operation is in flight.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] magA_q, magA_d;
  logic [31:0] magB_q, magB_d;
  logic        sign_q, sign_d;
  logic        bZero_q, bZero_d;
  logic        aMin_q, aMin_d;
  logic        bNeg1_q, bNeg1_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic        startReq;
  logic [31:0] absA, absB;
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [63:0] prodSigned;
  logic [32:0] divRem;
  logic        divFits;
  logic [31:0] divSub;
  logic [63:0] divNext;
  logic [31:0] quot;
  logic        lastIter;

  assign startReq = ((state_q == IDLE) || (state_q == DONE)) && (ctrl_MULT || ctrl_DIV);
  assign absA     = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign absB     = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
  assign lastIter = (cnt_q == 6'd31);

  // Multiply: accumulator high half gathers partial sums, low half holds the unconsumed multiplier bits.
  assign mulSum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, magA_q} : 33'd0);
  assign mulNext    = {mulSum, acc_q[31:1]};
  assign prodSigned = sign_q ? (64'd0 - mulNext) : mulNext;

  // Divide: partial remainder in the high half, dividend shifting out / quotient shifting in below.
  assign divRem  = acc_q[63:31];
  assign divFits = (divRem >= {1'b0, magB_q});
  assign divSub  = divRem[31:0] - magB_q;
  assign divNext = divFits ? {divSub, acc_q[30:0], 1'b1}
                           : {divRem[31:0], acc_q[30:0], 1'b0};
  assign quot    = sign_q ? (32'd0 - divNext[31:0]) : divNext[31:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    magA_d   = magA_q;
    magB_d   = magB_q;
    sign_d   = sign_q;
    bZero_d  = bZero_q;
    aMin_d   = aMin_q;
    bNeg1_d  = bNeg1_q;
    acc_d    = acc_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (startReq) begin
          magA_d  = absA;
          magB_d  = absB;
          sign_d  = data_operandA[31] ^ data_operandB[31];
          bZero_d = (data_operandB == 32'd0);
          aMin_d  = (data_operandA == 32'h8000_0000);
          bNeg1_d = (data_operandB == 32'hFFFF_FFFF);
          cnt_d   = 6'd0;
          if (ctrl_MULT) begin
            state_d = MULT;
            acc_d   = {32'd0, absB};
          end else if (data_operandB == 32'd0) begin
            // Divide by zero completes without iterating.
            state_d  = DONE;
            result_d = 32'd0;
            exc_d    = 1'b1;
            rdy_d    = 1'b1;
          end else begin
            state_d = DIV;
            acc_d   = {32'd0, absA};
          end
        end
      end
      MULT: begin
        acc_d = mulNext;
        cnt_d = cnt_q + 6'd1;
        if (lastIter) begin
          state_d  = DONE;
          rdy_d    = 1'b1;
          result_d = prodSigned[31:0];
          exc_d    = !((&prodSigned[63:31]) || !(|prodSigned[63:31]));
        end
      end
      DIV: begin
        acc_d = divNext;
        cnt_d = cnt_q + 6'd1;
        if (lastIter) begin
          state_d  = DONE;
          rdy_d    = 1'b1;
          result_d = quot;
          exc_d    = bZero_q || (aMin_q && bNeg1_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      magA_q   <= 32'd0;
      magB_q   <= 32'd0;
      sign_q   <= 1'b0;
      bZero_q  <= 1'b0;
      aMin_q   <= 1'b0;
      bNeg1_q  <= 1'b0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      magA_q   <= magA_d;
      magB_q   <= magB_d;
      sign_q   <= sign_d;
      bZero_q  <= bZero_d;
      aMin_q   <= aMin_d;
      bNeg1_q  <= bNeg1_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign stall          = (state_q == MULT) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: the driver pushes expected results from an
// arithmetic reference model, and a negedge monitor pops and compares on each resultRDY.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        stall;

  multdiv_unit dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .stall         (stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          rdyCycle;
    int          stallCycles;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   stallCnt = 0;

  always @(posedge clock) cycle <= cycle + 1;

  // Reference model: plain signed arithmetic on 64-bit integers.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input bit isMult, input int startNeg);
    exp_t   e;
    longint p;
    int     sa;
    int     sb;
    longint maxI;
    longint minI;
    maxI = 64'sh7FFF_FFFF;
    minI = -64'sh8000_0000;
    sa = int'(a);
    sb = int'(b);
    e.rdyCycle    = startNeg + 33;
    e.stallCycles = 32;
    if (isMult) begin
      p     = longint'(sa) * longint'(sb);
      e.res = p[31:0];
      e.exc = (p > maxI) || (p < minI);
    end else if (sb == 0) begin
      e.res         = 32'd0;
      e.exc         = 1'b1;
      e.rdyCycle    = startNeg + 1;
      e.stallCycles = 0;
    end else if (sa == int'(32'h8000_0000) && sb == -1) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      e.res = 32'(sa / sb);
      e.exc = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // mode 0 = multiply, 1 = divide, 2 = both pulses (behaves as multiply)
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int mode, input bit push);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = (mode != 1);
    ctrl_DIV      = (mode != 0);
    if (push) sbQ.push_back(model(a, b, mode != 1, cycle));
  endtask

  task automatic waitRdy();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      if (data_resultRDY) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL rdy_timeout: got no resultRDY expected one within 120 cycles");
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      stallCnt = 0;
    end else begin
      if (stall) stallCnt++;
      if (data_resultRDY) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rdy: got resultRDY=1 expected 0 (cycle %0d)", cycle);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("result", data_result, monE.res);
          checkOutput("exception", 32'(data_exception), 32'(monE.exc));
          checkOutput("latency", 32'(cycle), 32'(monE.rdyCycle));
          checkOutput("stall_cycles", 32'(stallCnt), 32'(monE.stallCycles));
        end
        stallCnt = 0;
      end
    end
  end

  initial begin
    int          sel;
    int          mode;
    int          s;
    logic [31:0] a;
    logic [31:0] b;

    repeat (3) @(negedge clock);
    checkOutput("reset_result", data_result, 32'd0);
    checkOutput("reset_exception", 32'(data_exception), 32'd0);
    checkOutput("reset_rdy", 32'(data_resultRDY), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    applyStimulus(32'd7, -32'sd3, 0, 1);                  waitRdy(); @(negedge clock);
    applyStimulus(32'h0001_0000, 32'h0001_0000, 0, 1);    waitRdy(); @(negedge clock);
    applyStimulus(32'h8000_0000, 32'd1, 0, 1);            waitRdy(); @(negedge clock);
    applyStimulus(-32'sd100, 32'd7, 1, 1);                waitRdy(); @(negedge clock);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1, 1);    waitRdy(); @(negedge clock);
    applyStimulus(32'd5, 32'd0, 1, 1);                    waitRdy(); @(negedge clock);

    // A divide pulse in the middle of a multiply must be ignored.
    applyStimulus(32'd1234, 32'd5678, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
    end
    ctrl_DIV = 1'b1;
    waitRdy();

    // Back-to-back: a new divide issued in the DONE cycle.
    applyStimulus(32'd7, -32'sd3, 0, 1);
    waitRdy();
    applyStimulus(32'd9, 32'd2, 1, 1);
    waitRdy();
    @(negedge clock);

    applyStimulus(32'd6, -32'sd7, 2, 1);                  waitRdy(); @(negedge clock);

    // Reset mid-multiply: outputs clear at once and the aborted operation never completes.
    applyStimulus(32'd100, 32'd200, 0, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_result", data_result, 32'd0);
    checkOutput("abort_exception", 32'(data_exception), 32'd0);
    checkOutput("abort_rdy", 32'(data_resultRDY), 32'd0);
    checkOutput("abort_stall", 32'(stall), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    applyStimulus(32'd3, 32'd4, 0, 1);                    waitRdy(); @(negedge clock);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      sel  = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) begin
        s = $urandom_range(0, 200);
        a = 32'(s - 100);
        s = $urandom_range(0, 40);
        b = 32'(s - 20);
      end else if (sel == 3) begin
        s = $urandom_range(0, 131072);
        a = 32'(s - 65536);
        s = $urandom_range(0, 131072);
        b = 32'(s - 65536);
      end
      applyStimulus(a, b, mode, 1);
      waitRdy();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Multicycle signed 32-bit multiply/divide unit in the execute stage, directly downstream of the instruction decoder. It starts on the decoder's mult/div pulses (ALU-format opcode with ALU op 00110 or 00111), iterates one bit per cycle, and raises a stall request that freezes the front of the pipeline until the result is ready. Its exception flag feeds the rstatus (r30) write path.

## Interface
- No parameters; width fixed at 32.
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-low; clears all state
- ctrl_MULT  in  1  single-cycle start pulse for multiply
- ctrl_DIV  in  1  single-cycle start pulse for divide
- data_operandA  in  32  rs value (multiplicand / dividend), two's complement
- data_operandB  in  32  rt value (multiplier / divisor), two's complement
- data_result  out  32  low 32 bits of product, or quotient
- data_exception  out  1  overflow or divide-by-zero; valid with data_resultRDY
- data_resultRDY  out  1  one-cycle pulse: result and exception valid
- stall  out  1  high while an operation is in flight and the result is not yet ready

## Operation
- States: IDLE, MULT, DIV, DONE. Reset enters IDLE.
- Start is accepted only in IDLE or DONE. ctrl_MULT and ctrl_DIV are sampled on the rising edge (start edge E0).
- If ctrl_MULT and ctrl_DIV are both high, the start is a multiply. Pulses in MULT or DIV are ignored.
- At E0:
  - latch |A| and |B| into internal magnitude registers.
  - latch result sign: A[31]^B[31].
  - latch the special-case flags (B==0, A==0x80000000, B==0xFFFFFFFF).
  - clear the 6-bit iteration counter.
- MULT: unsigned shift-add, one multiplier bit per edge, into a 64-bit accumulator. After 32 iterations, negate if the sign bit is set.
  - data_result = product[31:0].
  - data_exception = 1 when product[63:31] is not all-equal (signed result does not fit in 32 bits).
- DIV: unsigned restoring division, one quotient bit per edge, 32 iterations. Negate the quotient if the sign bit is set; the quotient truncates toward zero. The remainder is discarded.
  - Divide by zero (B==0): skip iteration and go IDLE→DONE at E0. Result 0x00000000, exception 1.
  - 0x80000000 / 0xFFFFFFFF: iterate normally. Result 0x80000000, exception 1.
- Transitions:
  - IDLE→MULT/DIV on start.
  - MULT/DIV→DONE on the 32nd iteration edge.
  - DONE→IDLE, or DONE→MULT/DIV if a new start is present in the DONE cycle (back-to-back).
- data_result and data_exception hold their last values after DONE until the next completion. They are meaningful only while data_resultRDY=1.

## Timing
- Reset (asynchronous assert, any state, including mid-operation): state IDLE, counter 0.
  - data_result=0, data_exception=0, data_resultRDY=0, stall=0.
  - An aborted operation produces no resultRDY.
- Normal latency: start at E0, iterations at E1..E32, DONE during the cycle after E32. data_resultRDY is high exactly that one cycle, then low after E33.
- Divide-by-zero latency: DONE during the cycle after E0.
- stall = (state==MULT or state==DIV). It is combinational from state, so it is 0 in IDLE and DONE.
  - The pipeline holds the mult/div instruction in execute while stall=1.
  - The pipeline writes back in the DONE cycle.
- A back-to-back start in DONE latches the new operands at E33. The next resultRDY follows 33 edges later.
- All outputs are registered except stall.

## Test plan
- Multiply 7 × −3: start pulse; data_resultRDY rises 32 edges after the start edge. Result 0xFFFFFFEB, exception 0. stall high for exactly 32 cycles.
- Multiply 0x00010000 × 0x00010000: result 0x00000000, exception 1. Also 0x80000000 × 0x00000001: result 0x80000000, exception 0.
- Divide −100 / 7: result 0xFFFFFFF2 (−14), exception 0. Divide 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception 1.
- Divide 5 / 0: resultRDY in the cycle right after the start edge. Result 0, exception 1, stall never asserted.
- Back-to-back operations and ignored pulses:
  - Start a multiply, and pulse ctrl_DIV mid-operation: the pulse is ignored.
  - In the DONE cycle, pulse ctrl_DIV 9/2: the first result 0x… reports correctly, and the second resultRDY gives 4.
  - Assert ctrl_MULT and ctrl_DIV together: the unit performs a multiply.
- Drive reset low at iteration 15:
  - All outputs go to 0 immediately and no resultRDY follows.
  - After reset releases, a fresh 3 × 4 returns 12.
